uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter BAUD, default 115200, meaning the line bit rate in bits/s.
REQ-002 The block SHALL have parameter F, default 50000000, meaning the clk frequency in Hz.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-006 The block SHALL have port data, output, 8 bits: the last correctly framed received byte.
REQ-007 The block SHALL have port valid, output, 1 bit: a one-clk pulse when data is updated.
REQ-008 The block SHALL have port frame_err, output, 1 bit: a one-clk pulse when a stop bit is sampled low.

Function
REQ-009 The block SHALL pass rx through a 2-flop synchronizer; all further references to rx mean the synchronized value rx_s.
REQ-010 Bit period DIV SHALL be F/BAUD (integer division, truncated). HALF SHALL be DIV/2 (truncated). The bit counter SHALL be wide enough for DIV-1.
REQ-011 The frame format SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with no parity.
REQ-012 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-013 IDLE: on rx_s == 0, the FSM SHALL go to START and clear the bit counter.
REQ-014 START: when the counter reaches HALF-1, the FSM SHALL resample rx_s. If it is 0, the FSM SHALL go to DATA and clear the counter. If it is 1 (glitch), the FSM SHALL return to IDLE with no output pulse.
REQ-015 DATA: every DIV clocks, the FSM SHALL sample rx_s into the shift register at bit index 0..7. After index 7 it SHALL go to STOP with the counter cleared.
REQ-016 STOP: after DIV clocks, the FSM SHALL sample rx_s.
   - If rx_s is 1: data SHALL take the shifted byte and valid SHALL be 1 in the next cycle.
   - If rx_s is 0: data SHALL be held and frame_err SHALL be 1 in the next cycle.
REQ-017 valid and frame_err SHALL never be high together, and each SHALL be high for exactly one clk per frame.
REQ-018 After frame_err, the FSM SHALL stay in IDLE-wait until rx_s == 1 before arming start detection again, so a break does not retrigger.
REQ-019 A start edge arriving in the cycle right after the stop sample SHALL be accepted, so back-to-back frames need no extra idle time.
REQ-020 data SHALL hold its value between valid pulses.
REQ-021 Latency from the rx falling edge of the start bit to the valid pulse SHALL be 2 + HALF + 9*DIV + 1 clks, within ±1.

Reset
REQ-022 While rst == 1 at a clk edge, the block SHALL set:
   - state = IDLE
   - data = 8'h00, valid = 0, frame_err = 0
   - synchronizer flops = 1
   - counters = 0
   - shift register = 0
REQ-023 Reset asserted mid-frame SHALL abort the frame: no valid or frame_err pulse, and the partial byte is discarded.
REQ-024 After reset is released, the block SHALL wait for a new falling edge. A line already low SHALL be treated as a start after 2 sync cycles.

Structure
REQ-025 The UART constants SHALL live in a shared package/include, uart_defs, used by both the transmitter and uart_rx. These are the frame bit count (10), the data width (8), the idle level (1), and the FSM state encodings.
REQ-026 Bit timing SHALL be produced by one sub-module, baud_gen. Its inputs are clk, rst and a synchronous clear. It SHALL output a half-bit tick and a full-bit tick, parameterized by DIV.
REQ-027 The synchronizer, FSM, shift register and output registers SHALL reside in uart_rx.

Verification
REQ-028 The bench SHALL run with F=1000 and BAUD=100 (DIV=10, HALF=5), using a behavioral transmitter model.
REQ-029 Scenario: send 8'hA5 with a correct stop bit -> one valid pulse, data = 8'hA5, frame_err = 0, latency within REQ-021.
REQ-030 Scenario: send 8'h00, then 8'hFF back-to-back with no idle time -> two valid pulses, data 8'h00 then 8'hFF.
REQ-031 Scenario: send 8'h3C with the stop bit forced to 0 and rx held low for 30 clks -> one frame_err pulse, data unchanged, no retrigger until rx returns to 1.
REQ-032 Scenario: a 3-clk low glitch on rx while idle -> no valid, no frame_err, FSM back in IDLE.
REQ-033 Scenario: assert rst for 1 clk during bit 4 of 8'h5A, then send 8'h81 -> no pulse for the aborted frame, then valid with data = 8'h81.
REQ-034 Scenario: hold rst high for several clks -> data = 0, valid = 0, frame_err = 0 on the cycle after the first rst edge.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART framing constants and receiver FSM state encodings,
// used by both the transmitter and the receiver.
package uart_defs;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/baud_gen.sv
// Bit-period counter: half-bit tick for start validation and full-bit tick
// for data/stop sampling. Restarts from zero on a synchronous clear.
module baud_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic half_tick,
   output logic full_tick
);

   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_reg;

   assign full_tick = (cnt_reg == CW'(DIV - 1));
   assign half_tick = (cnt_reg == CW'(HALF - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg <= '0;
      end else if (full_tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, start-bit validation at
// mid-bit, LSB-first shift register and one-clock valid / frame_err pulses.
module uart_rx
   import uart_defs::*;
#(
   parameter int BAUD = 115200,
   parameter int F    = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int DIV = F / BAUD;
   localparam int IW  = $clog2(DATA_BITS);

   logic                 sync1_reg;
   logic                 rx_s_reg;
   logic [1:0]           state_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic [IW-1:0]        bit_idx_reg;
   logic                 armed_reg;
   logic [DATA_BITS-1:0] data_reg;
   logic                 valid_reg;
   logic                 frame_err_reg;

   logic clr;
   logic half_tick;
   logic full_tick;

   // Restart bit timing on a detected start edge and on a confirmed start bit.
   always_comb begin
      clr = 1'b0;
      if (state_reg == ST_IDLE && armed_reg && !rx_s_reg) begin
         clr = 1'b1;
      end else if (state_reg == ST_START && half_tick && !rx_s_reg) begin
         clr = 1'b1;
      end
   end

   baud_gen #(
      .DIV (DIV)
   ) u_baud_gen (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg     <= IDLE_LEVEL;
         rx_s_reg      <= IDLE_LEVEL;
         state_reg     <= ST_IDLE;
         shift_reg     <= '0;
         bit_idx_reg   <= '0;
         armed_reg     <= 1'b1;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         sync1_reg     <= rx;
         rx_s_reg      <= sync1_reg;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               // After a framing error the line must return high before a new start counts.
               if (!armed_reg) begin
                  if (rx_s_reg) begin
                     armed_reg <= 1'b1;
                  end
               end else if (!rx_s_reg) begin
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (half_tick) begin
                  bit_idx_reg <= '0;
                  state_reg   <= rx_s_reg ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (full_tick) begin
                  shift_reg   <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                  bit_idx_reg <= bit_idx_reg + 1'b1;
                  if (bit_idx_reg == IW'(DATA_BITS - 1)) begin
                     state_reg <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (full_tick) begin
                  state_reg <= ST_IDLE;
                  if (rx_s_reg) begin
                     data_reg  <= shift_reg;
                     valid_reg <= 1'b1;
                  end else begin
                     frame_err_reg <= 1'b1;
                     armed_reg     <= 1'b0;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign data      = data_reg;
   assign valid     = valid_reg;
   assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at F=1000, BAUD=100 with a behavioural
// transmitter and a scoreboard of expected output pulses.
module tb_uart_rx;

   localparam int F    = 1000;
   localparam int BAUD = 100;
   localparam int DIV  = F / BAUD;
   localparam int HALF = DIV / 2;
   localparam int LAT  = 2 + HALF + 9 * DIV + 1;

   typedef struct {
      logic       is_err;
      logic [7:0] d;
      int         start_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t sb[$];
   logic [7:0] exp_good = 8'h00;

   uart_rx #(
      .BAUD (BAUD),
      .F    (F)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (valid === 1'b1 || frame_err === 1'b1) begin
         exp_t e;
         int   lat;
         check("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
         check("pulse_expected", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            lat = cyc - e.start_cyc;
            $display("rx pulse: valid=%0b frame_err=%0b data=%02h latency=%0d", valid, frame_err, data, lat);
            check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
            check("pulse_data", {24'd0, data}, {24'd0, e.d});
            check("latency", {31'd0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 32'd1);
         end
      end
   end

   task automatic tx_bit(input logic v);
      rx = v;
      repeat (DIV) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v);
      exp_t e;
      if (stop_v) exp_good = b;
      e.is_err    = ~stop_v;
      e.d         = exp_good;
      e.start_cyc = cyc;
      sb.push_back(e);
      tx_bit(1'b0);
      for (int i = 0; i < 8; i++) tx_bit(b[i]);
      tx_bit(stop_v);
   endtask

   initial begin
      logic [7:0] part;

      // Reset state on the cycle after the first reset edge
      @(posedge clk); #1;
      check("rst_data", {24'd0, data}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk); #1;

      // Single good frame
      send_byte(8'hA5, 1'b1);
      repeat (20) @(posedge clk); #1;
      check("a5_drained", sb.size(), 32'd0);

      // Back-to-back frames with no idle gap
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      repeat (20) @(posedge clk); #1;
      check("b2b_drained", sb.size(), 32'd0);

      // Framing error followed by a held break; no retrigger expected
      send_byte(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (30) @(posedge clk); #1;
      rx = 1'b1;
      repeat (150) @(posedge clk); #1;
      check("ferr_drained", sb.size(), 32'd0);
      check("ferr_data_held", {24'd0, data}, 32'hFF);

      // Short glitch while idle
      rx = 1'b0;
      repeat (3) @(posedge clk); #1;
      rx = 1'b1;
      repeat (150) @(posedge clk); #1;
      check("glitch_no_pulse", sb.size(), 32'd0);

      // Reset during bit 4 of 8'h5A aborts the frame
      part = 8'h5A;
      tx_bit(1'b0);
      for (int i = 0; i < 4; i++) tx_bit(part[i]);
      rx = part[4];
      repeat (HALF) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rx  = 1'b1;
      exp_good = 8'h00;
      repeat (150) @(posedge clk); #1;
      check("abort_no_pulse", sb.size(), 32'd0);
      check("abort_data_cleared", {24'd0, data}, 32'd0);

      send_byte(8'h81, 1'b1);
      repeat (20) @(posedge clk); #1;
      check("post_abort_drained", sb.size(), 32'd0);
      check("post_abort_data", {24'd0, data}, 32'h81);

      // Reset held high clears a non-zero data register
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst2_data", {24'd0, data}, 32'd0);
      check("rst2_valid", {31'd0, valid}, 32'd0);
      check("rst2_ferr", {31'd0, frame_err}, 32'd0);
      repeat (4) @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
